fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch stage directly downstream of the program counter. It takes each PC value the counter presents, issues one word read to instruction memory with a req/ack handshake, and buffers the returned instructions with their PCs in a small FIFO for the decode stage. A branch/jump redirect flushes all buffered and in-flight work. Back-pressure to the PC counter is a single `pc_ready` stall signal.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `AW`, 32: PC and address width.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-low; `reset==0` at a posedge resets the block.
- `pc_in` in AW: word address from the PC counter; word-addressed, no alignment bits.
- `pc_valid` in 1: `pc_in` is valid this cycle.
- `pc_ready` out 1: block accepts `pc_in` this cycle (combinational).
- `flush` in 1: redirect; discard queue and in-flight fetch.
- `imem_req` out 1: memory request; held with `imem_addr` stable until ack.
- `imem_addr` out AW: fetch address.
- `imem_ack` in 1: sampled only while `imem_req==1`; `imem_rdata` is valid the same cycle.
- `imem_rdata` in 32: instruction word.
- `inst_valid` out 1: FIFO head valid (`count != 0`).
- `inst` out 32: head instruction.
- `inst_pc` out AW: head PC.
- `inst_ready` in 1: decode consumes the head this cycle.

## Operation
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; the result will be kept.
  - DROP: request outstanding; the result will be discarded.
- `imem_req = (state != IDLE)`. `imem_addr` is a register loaded on accept.
- `pc_ready = reset && !flush && ((state==IDLE && count<DEPTH) || (state==WAIT && imem_ack && count+1<DEPTH))`.
  - The outstanding fetch always has a reserved slot.
  - Pops are ignored in the ready calculation (conservative).
- Accept (`pc_valid && pc_ready`): `imem_addr <= pc_in`; next state WAIT.
- WAIT with `imem_ack` and no flush:
  - Push `{imem_addr, imem_rdata}` to the tail.
  - Next state is WAIT if a new PC is accepted the same cycle (back-to-back), otherwise IDLE.
- WAIT without ack: hold. `imem_addr` and `imem_req` stay unchanged.
- Pop: `inst_valid && inst_ready && !flush`.
  - Push and pop in the same cycle leave `count` unchanged; both pointers advance.
  - The FIFO cannot overflow: every push has a reserved slot.
- Flush at a posedge:
  - `count`, read pointer and write pointer all go to 0. No push and no pop occur.
  - WAIT with ack that cycle: data is discarded; next state IDLE.
  - WAIT without ack: next state DROP.
  - IDLE stays IDLE. DROP stays DROP.
- DROP: hold `imem_req`/`imem_addr`. On `imem_ack`, discard data and go to IDLE. `pc_ready=0` throughout DROP.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits.
- Reset: state IDLE, `count=0`, pointers 0, `imem_addr=0`.
  - Reset outputs: `imem_req=0`, `inst_valid=0`, `pc_ready=0` while `reset==0`.
  - FIFO data contents are don't-care.
  - An outstanding request is abandoned; memory must tolerate `imem_req` dropping without ack.

## Timing
- Zero-wait memory (ack in the first cycle `imem_req` is high):
  - PC accepted at edge E; `imem_req` high in cycle E..E+1.
  - Push at E+1; `inst_valid` high after E+1. Latency from PC accept to `inst_valid` is 2 edges.
- Sustained throughput is 1 fetch/cycle with back-to-back accept and zero-wait memory, while `count+1 < DEPTH`.
- `flush` takes effect at the edge where it is high. `inst_valid=0` from the next cycle.
- The first post-flush PC can be accepted:
  - the cycle after the flush, if the state was IDLE or the ack arrived with the flush;
  - otherwise, in the cycle after DROP ends.
- Without flush, `inst`/`inst_pc` are stable while `inst_valid && !inst_ready`.

## Test plan
- Reset/basic fetch:
  - Stimulus: hold `reset=0` for 2 cycles, then `pc_in=0x10`, `pc_valid=1` for one cycle; memory acks immediately with `0x8C010004`.
  - Required: during reset `imem_req=0` and `inst_valid=0`; then `imem_addr=0x10`, and `inst_valid=1` with `inst=0x8C010004`, `inst_pc=0x10` two edges after accept.
- Streaming and full:
  - Stimulus: PCs 0..7 with `pc_valid=1` every cycle, zero-wait memory, `inst_ready=0`.
  - Required: exactly 4 PCs accepted (0..3); `pc_ready` drops once 3 are queued plus 1 outstanding; `count` holds at 4 with no overflow.
  - Stimulus continued: release `inst_ready`.
  - Required: instructions pop in order 0,1,2,3; PCs 4.. resume.
- Wait states:
  - Stimulus: ack delayed 3 cycles, `pc_valid` held.
  - Required: `imem_addr` is stable for all 4 request cycles, `pc_ready` is high only in the ack cycle, and the data is pushed once.
- Flush in flight:
  - Stimulus: with 2 entries queued and a request outstanding, pulse `flush` with no ack; ack arrives 2 cycles later; then `pc_in=0x40` is presented.
  - Required: `inst_valid=0` after the flush edge; state DROP; the late data is never pushed; `0x40` is accepted in the cycle after the ack and is the next instruction delivered.
- Simultaneous events:
  - Stimulus: flush coinciding with an ack and with `inst_ready=1`.
  - Required: no push, no pop, `count=0`, state IDLE.
  - Stimulus: push and pop in the same cycle at `count=2`.
  - Required: `count` stays 2 and pointers wrap correctly across 10 iterations.
- Reset mid-operation:
  - Stimulus: drive `reset=0` while in WAIT with 3 entries queued.
  - Required: the next cycle shows `imem_req=0`, `inst_valid=0`, `count=0`; a later ack is ignored.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: PC counter handshake, instruction memory req/ack and decode-side FIFO head.
// master = fetch_queue, slave = surrounding pipeline / memory.
interface fetch_queue_if #(
  parameter int AW = 32
);
  logic [AW-1:0] pc_in;
  logic          pc_valid;
  logic          pc_ready;
  logic          flush;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;

  modport master (
    input  pc_in, pc_valid, flush, imem_ack, imem_rdata, inst_ready,
    output pc_ready, imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output pc_in, pc_valid, flush, imem_ack, imem_rdata, inst_ready,
    input  pc_ready, imem_req, imem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding imem read per accepted PC, results buffered
// with their PCs in a DEPTH-entry FIFO; a redirect flushes queued and in-flight work.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];
  logic [AW-1:0] pc_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_d [DEPTH];

  logic ack_wait;
  logic pc_ready;
  logic accept;
  logic push;
  logic pop;

  // The outstanding fetch always owns a slot, so readiness ignores same-cycle pops.
  always_comb begin
    ack_wait = (state_q == S_WAIT) && bus.imem_ack;
    pc_ready = reset && !bus.flush &&
               (((state_q == S_IDLE) && (count_q < CW'(DEPTH))) ||
                (ack_wait && ((count_q + CW'(1)) < CW'(DEPTH))));
    accept   = bus.pc_valid && pc_ready;
    push     = ack_wait && !bus.flush;
    pop      = (count_q != '0) && bus.inst_ready && !bus.flush;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.flush)        state_d = bus.imem_ack ? S_IDLE : S_DROP;
        else if (bus.imem_ack) state_d = accept ? S_WAIT : S_IDLE;
      end
      S_DROP: if (bus.imem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = accept ? bus.pc_in : addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        inst_mem_d[wr_ptr_q] = bus.imem_rdata;
        pc_mem_d[wr_ptr_q]   = addr_q;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      addr_q   <= addr_d;
    end
  end

  // FIFO storage carries no reset; only count/pointers decide what is valid.
  always_ff @(posedge clk) begin
    inst_mem_q <= inst_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

  assign bus.pc_ready   = pc_ready;
  assign bus.imem_req   = (state_q != S_IDLE);
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst       = inst_mem_q[rd_ptr_q];
  assign bus.inst_pc    = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, streaming/full, wait states, flush, simultaneous events.
module tb_fetch_queue;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic clk = 1'b0;
  logic reset;
  logic mem_auto;
  logic ack_man;
  int   checks = 0;
  int   failures = 0;

  fetch_queue_if #(.AW(32)) bus ();

  fetch_queue #(.DEPTH(4), .AW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'h8C01_0004 : {16'hC0DE, a[15:0]};
  endfunction

  assign bus.imem_ack   = mem_auto ? bus.imem_req : ack_man;
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.pc_valid = 1'b0; bus.flush = 1'b0; bus.inst_ready = 1'b0;
    mem_auto = 1'b1; ack_man = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.pc_valid = 1'b1; bus.pc_in = 32'h10;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", bus.imem_req); end
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.inst_valid); end
      checks++; if (bus.pc_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", bus.pc_ready); end
      tick();
    end
    reset = 1'b1; #1;
    checks++; if (bus.pc_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%0b exp=1", bus.pc_ready); end
    tick();
    bus.pc_valid = 1'b0;
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL basic_req got=%0b exp=1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h10) begin failures++; $display("FAIL basic_addr got=%h exp=00000010", bus.imem_addr); end
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b exp=0", bus.inst_valid); end
    tick();
    checks++; if (bus.inst_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", bus.inst_valid); end
    checks++; if (bus.inst !== 32'h8C01_0004) begin failures++; $display("FAIL basic_inst got=%h exp=8c010004", bus.inst); end
    checks++; if (bus.inst_pc !== 32'h10) begin failures++; $display("FAIL basic_pc got=%h exp=00000010", bus.inst_pc); end
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL basic_req_drop got=%0b exp=0", bus.imem_req); end
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL basic_pop got=%0b exp=0", bus.inst_valid); end
  endtask

  task automatic test_streaming();
    logic [7:0]  exp_rdy;
    logic [31:0] next_pc;
    logic [31:0] pops [32];
    logic        acc;
    int          n;
    do_reset();
    exp_rdy = 8'b0000_1111;
    next_pc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.pc_in = next_pc; bus.pc_valid = 1'b1; #1;
      checks++; if (bus.pc_ready !== exp_rdy[i]) begin failures++; $display("FAIL stream_ready[%0d] got=%0b exp=%0b", i, bus.pc_ready, exp_rdy[i]); end
      acc = bus.pc_ready;
      tick();
      if (acc) next_pc++;
    end
    checks++; if (next_pc !== 32'd4) begin failures++; $display("FAIL stream_accepted got=%0d exp=4", next_pc); end
    checks++; if (dut.count_q !== 3'd4) begin failures++; $display("FAIL stream_full_count got=%0d exp=4", dut.count_q); end
    checks++; if (bus.inst_pc !== 32'd0) begin failures++; $display("FAIL stream_head got=%h exp=0", bus.inst_pc); end
    bus.inst_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      bus.pc_in = next_pc; bus.pc_valid = (next_pc < 8); #1;
      if (bus.inst_valid && n < 32) begin
        pops[n] = bus.inst_pc;
        checks++; if (bus.inst !== mem_word(bus.inst_pc)) begin failures++; $display("FAIL stream_data pc=%h got=%h exp=%h", bus.inst_pc, bus.inst, mem_word(bus.inst_pc)); end
        n++;
      end
      acc = bus.pc_valid && bus.pc_ready;
      tick();
      if (acc) next_pc++;
    end
    bus.pc_valid = 1'b0; bus.inst_ready = 1'b0;
    checks++; if (n != 8) begin failures++; $display("FAIL stream_pop_count got=%0d exp=8", n); end
    for (int i = 0; i < 8 && i < n; i++) begin
      checks++; if (pops[i] !== 32'(i)) begin failures++; $display("FAIL stream_order[%0d] got=%h exp=%h", i, pops[i], i); end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    mem_auto = 1'b0; ack_man = 1'b0;
    bus.pc_in = 32'h20; bus.pc_valid = 1'b1;
    tick();
    bus.pc_in = 32'h24;
    for (int i = 0; i < 4; i++) begin
      ack_man = (i == 3); #1;
      checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL wait_req[%0d] got=%0b exp=1", i, bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h20) begin failures++; $display("FAIL wait_addr[%0d] got=%h exp=00000020", i, bus.imem_addr); end
      checks++; if (bus.pc_ready !== (i == 3)) begin failures++; $display("FAIL wait_ready[%0d] got=%0b exp=%0b", i, bus.pc_ready, i == 3); end
      tick();
    end
    ack_man = 1'b0; bus.pc_valid = 1'b0;
    checks++; if (dut.count_q !== 3'd1) begin failures++; $display("FAIL wait_push got=%0d exp=1", dut.count_q); end
    checks++; if (bus.inst_pc !== 32'h20) begin failures++; $display("FAIL wait_pc got=%h exp=00000020", bus.inst_pc); end
    checks++; if (bus.imem_addr !== 32'h24) begin failures++; $display("FAIL wait_next_addr got=%h exp=00000024", bus.imem_addr); end
    tick();
    checks++; if (dut.count_q !== 3'd1) begin failures++; $display("FAIL wait_single_push got=%0d exp=1", dut.count_q); end
  endtask

  task automatic test_flush_inflight();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.pc_in = 32'h30 + 32'(i); bus.pc_valid = 1'b1;
      tick();
    end
    mem_auto = 1'b0; ack_man = 1'b0; bus.pc_valid = 1'b0;
    checks++; if (dut.count_q !== 3'd2) begin failures++; $display("FAIL flush_pre_count got=%0d exp=2", dut.count_q); end
    bus.flush = 1'b1; #1;
    checks++; if (bus.pc_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", bus.pc_ready); end
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", bus.inst_valid); end
    checks++; if (dut.state_q !== ST_DROP) begin failures++; $display("FAIL flush_state got=%0d exp=%0d", dut.state_q, ST_DROP); end
    checks++; if (bus.imem_addr !== 32'h32) begin failures++; $display("FAIL flush_hold_addr got=%h exp=00000032", bus.imem_addr); end
    bus.pc_in = 32'h40; bus.pc_valid = 1'b1; #1;
    checks++; if (bus.pc_ready !== 1'b0) begin failures++; $display("FAIL drop_ready0 got=%0b exp=0", bus.pc_ready); end
    tick();
    ack_man = 1'b1; #1;
    checks++; if (bus.pc_ready !== 1'b0) begin failures++; $display("FAIL drop_ready1 got=%0b exp=0", bus.pc_ready); end
    tick();
    ack_man = 1'b0; #1;
    checks++; if (dut.count_q !== 3'd0) begin failures++; $display("FAIL drop_no_push got=%0d exp=0", dut.count_q); end
    checks++; if (bus.pc_ready !== 1'b1) begin failures++; $display("FAIL drop_after_ready got=%0b exp=1", bus.pc_ready); end
    tick();
    mem_auto = 1'b1; bus.pc_valid = 1'b0;
    checks++; if (bus.imem_addr !== 32'h40) begin failures++; $display("FAIL post_flush_addr got=%h exp=00000040", bus.imem_addr); end
    tick();
    checks++; if (bus.inst_valid !== 1'b1) begin failures++; $display("FAIL post_flush_valid got=%0b exp=1", bus.inst_valid); end
    checks++; if (bus.inst_pc !== 32'h40) begin failures++; $display("FAIL post_flush_pc got=%h exp=00000040", bus.inst_pc); end
    checks++; if (bus.inst !== mem_word(32'h40)) begin failures++; $display("FAIL post_flush_inst got=%h exp=%h", bus.inst, mem_word(32'h40)); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus.pc_in = 32'h50 + 32'(i); bus.pc_valid = 1'b1;
      tick();
    end
    bus.pc_valid = 1'b0; bus.flush = 1'b1; bus.inst_ready = 1'b1; #1;
    checks++; if (bus.imem_ack !== 1'b1) begin failures++; $display("FAIL simul_ack got=%0b exp=1", bus.imem_ack); end
    tick();
    bus.flush = 1'b0; bus.inst_ready = 1'b0;
    checks++; if (dut.count_q !== 3'd0) begin failures++; $display("FAIL simul_count got=%0d exp=0", dut.count_q); end
    checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL simul_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
    checks++; if (dut.rd_ptr_q !== 2'd0 || dut.wr_ptr_q !== 2'd0) begin failures++; $display("FAIL simul_ptrs got=%0d/%0d exp=0/0", dut.rd_ptr_q, dut.wr_ptr_q); end
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL simul_valid got=%0b exp=0", bus.inst_valid); end
  endtask

  task automatic test_push_pop_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.pc_in = 32'h60 + 32'(i); bus.pc_valid = 1'b1;
      tick();
    end
    checks++; if (dut.count_q !== 3'd2) begin failures++; $display("FAIL wrap_pre_count got=%0d exp=2", dut.count_q); end
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.pc_in = 32'h63 + 32'(i); #1;
      checks++; if (bus.inst_pc !== 32'h60 + 32'(i)) begin failures++; $display("FAIL wrap_head[%0d] got=%h exp=%h", i, bus.inst_pc, 32'h60 + 32'(i)); end
      checks++; if (bus.pc_ready !== 1'b1) begin failures++; $display("FAIL wrap_ready[%0d] got=%0b exp=1", i, bus.pc_ready); end
      tick();
      checks++; if (dut.count_q !== 3'd2) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=2", i, dut.count_q); end
      checks++; if (dut.rd_ptr_q !== 2'((i + 1) % 4)) begin failures++; $display("FAIL wrap_rd[%0d] got=%0d exp=%0d", i, dut.rd_ptr_q, (i + 1) % 4); end
      checks++; if (dut.wr_ptr_q !== 2'((i + 3) % 4)) begin failures++; $display("FAIL wrap_wr[%0d] got=%0d exp=%0d", i, dut.wr_ptr_q, (i + 3) % 4); end
    end
    bus.pc_valid = 1'b0; bus.inst_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.pc_in = 32'h70 + 32'(i); bus.pc_valid = 1'b1;
      tick();
    end
    mem_auto = 1'b0; ack_man = 1'b0; bus.pc_valid = 1'b0;
    checks++; if (dut.state_q !== ST_WAIT || dut.count_q !== 3'd3) begin failures++; $display("FAIL mid_pre got=%0d/%0d exp=%0d/3", dut.state_q, dut.count_q, ST_WAIT); end
    reset = 1'b0; #1;
    checks++; if (bus.pc_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%0b exp=0", bus.pc_ready); end
    tick();
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL mid_req got=%0b exp=0", bus.imem_req); end
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0b exp=0", bus.inst_valid); end
    checks++; if (dut.count_q !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", dut.count_q); end
    reset = 1'b1; ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    checks++; if (dut.count_q !== 3'd0 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL mid_late_ack got=%0d/%0b exp=0/0", dut.count_q, bus.inst_valid); end
    checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL mid_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
  endtask

  initial begin
    reset = 1'b0; mem_auto = 1'b1; ack_man = 1'b0;
    bus.pc_in = '0; bus.pc_valid = 1'b0; bus.flush = 1'b0; bus.inst_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_wait_states();
    test_flush_inflight();
    test_simultaneous();
    test_push_pop_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
